// File: rtl/loop_counter_pkg.sv
// Shared definitions for the loop counter: count width, period-counter width
// and the two-state FSM encoding.
package loop_counter_pkg;
  localparam int CNT_W    = 20;
  localparam int PERIOD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/loop_counter_dec.sv
// Decrementer: y = a - 1, with borrow raised when a is zero.
module loop_counter_dec #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y,
  output logic         borrow
);
  assign {borrow, y} = {1'b0, a} - {{W{1'b0}}, 1'b1};
endmodule

// File: rtl/loop_counter.sv
// Loadable down-counter with terminal-count pulse, optional auto-reload and a
// saturating count of completed periods.
//   state | meaning
//   IDLE  | waiting for a load; load_ready high
//   RUN   | counting enabled cycles down to terminal count; busy high
module loop_counter #(
  parameter int CNT_W = loop_counter_pkg::CNT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic [CNT_W-1:0]                     load_value,
  input  logic                                 auto_reload,
  input  logic                                 enable,
  input  logic                                 abort,
  output logic [CNT_W-1:0]                     count,
  output logic                                 busy,
  output logic                                 tc,
  output logic [loop_counter_pkg::PERIOD_W-1:0] periods
);
  import loop_counter_pkg::*;

  state_t             state;
  logic [CNT_W-1:0]   reload;
  logic               auto_q;
  logic [CNT_W-1:0]   dec_y;
  logic               dec_borrow;
  logic               at_last;

  loop_counter_dec #(.W(CNT_W)) u_dec (
    .a      (count),
    .y      (dec_y),
    .borrow (dec_borrow)
  );

  // count == 1 exactly when the decrementer yields zero without borrowing
  assign at_last    = (dec_y == '0) && !dec_borrow;
  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      auto_q  <= 1'b0;
      tc      <= 1'b0;
      periods <= '0;
    end else begin
      tc <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              count  <= load_value;
              reload <= load_value;
              auto_q <= auto_reload;
              if (load_value == '0) begin
                tc      <= 1'b1;
                periods <= PERIOD_W'(1);
              end else begin
                state   <= RUN;
                periods <= '0;
              end
            end
          end
          RUN: begin
            if (enable) begin
              if (at_last) begin
                tc <= 1'b1;
                if (periods != '1) periods <= periods + PERIOD_W'(1);
                if (auto_q) begin
                  count <= reload;
                end else begin
                  count <= '0;
                  state <= IDLE;
                end
              end else begin
                count <= dec_y;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_loop_counter.sv
// Self-checking bench for loop_counter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_loop_counter;
  localparam int W = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  load_value = '0;
  logic          auto_reload = 1'b0;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  count;
  logic          busy;
  logic          tc;
  logic [7:0]    periods;

  int n_chk  = 0;
  int n_fail = 0;

  loop_counter #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .auto_reload(auto_reload), .enable(enable),
    .abort(abort), .count(count), .busy(busy), .tc(tc), .periods(periods)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a period is "remaining enabled cycles"; completions
  // are tallied as an unbounded integer and clipped at 255 when compared.
  bit      m_running;
  longint  m_left;
  longint  m_len;
  bit      m_repeat;
  bit      m_pulse;
  int      m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running = 0; m_left = 0; m_len = 0; m_repeat = 0; m_pulse = 0; m_done = 0;
    end else begin
      m_pulse = 0;
      if (abort) begin
        m_running = 0;
        m_left    = 0;
      end else if (!m_running) begin
        if (load_valid) begin
          m_len = load_value; m_left = load_value; m_repeat = auto_reload;
          if (load_value == 0) begin
            m_pulse = 1; m_done = 1;
          end else begin
            m_running = 1; m_done = 0;
          end
        end
      end else if (enable) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_pulse = 1;
          m_done  = m_done + 1;
          if (m_repeat) m_left = m_len;
          else          m_running = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("count", count, m_left);
      chk("tc", tc, m_pulse);
      chk("periods", periods, (m_done > 255) ? 255 : m_done);
      chk("busy", busy, m_running);
      chk("load_ready", load_ready, !m_running);
      if (busy) chk("borrow_in_run", dut.u_dec.borrow, 0);
    end
  end

  task automatic drive(input bit lv, input logic [W-1:0] v, input bit ar,
                       input bit en, input bit ab);
    load_valid = lv; load_value = v; auto_reload = ar; enable = en; abort = ab;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_periods", periods, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 1);
    @(negedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("reset_count", count, 0);
    chk("reset_ready", load_ready, 1);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    #3 rst = 1'b0;

    // load 3, single shot
    cyc(); drive(1, 3, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 0);
    chk("l3_c0", count, 3); chk("l3_busy", busy, 1);
    cyc(); chk("l3_c1", count, 2);
    cyc(); chk("l3_c2", count, 1); chk("l3_tc_early", tc, 0);
    cyc(); chk("l3_c3", count, 0); chk("l3_tc", tc, 1);
    chk("l3_busy_fall", busy, 0); chk("l3_periods", periods, 1);
    cyc(); chk("l3_tc_one_cycle", tc, 0);

    // load 0
    drive(1, 0, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 0);
    chk("l0_tc", tc, 1); chk("l0_periods", periods, 1);
    chk("l0_ready", load_ready, 1); chk("l0_busy", busy, 0);

    // load 2 with auto-reload until saturation
    cyc(); drive(1, 2, 1, 1, 0);
    cyc(); drive(0, 0, 0, 1, 0);
    chk("ar_c0", count, 2);
    cyc(); chk("ar_c1", count, 1);
    cyc(); chk("ar_c2", count, 2); chk("ar_tc", tc, 1); chk("ar_p1", periods, 1);
    repeat (600) cyc();
    chk("ar_sat", periods, 255); chk("ar_still_busy", busy, 1);
    drive(0, 0, 0, 1, 1);
    cyc(); drive(0, 0, 0, 0, 0);
    chk("ar_abort_idle", busy, 0);

    // max load, enable toggling, loads ignored in RUN
    cyc(); drive(1, 20'hFFFFF, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(); drive(1, 5, 1, (i % 2) == 0, 0);
    end
    cyc();
    chk("max_count", count, 20'hFFFF5); chk("max_busy", busy, 1);
    drive(0, 0, 0, 0, 1);
    cyc(); drive(0, 0, 0, 0, 0);

    // load 5, abort after 2 cycles with load_valid high
    cyc(); drive(1, 5, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 0);
    cyc(); cyc(); drive(1, 7, 0, 1, 1);
    cyc(); drive(0, 0, 0, 1, 0);
    chk("ab_count", count, 0); chk("ab_tc", tc, 0); chk("ab_busy", busy, 0);

    // async reset mid-RUN
    cyc(); drive(1, 9, 0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 0);
    cyc();
    async_reset_check();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      drive(($urandom % 3) == 0, $urandom % 8, $urandom % 2,
            ($urandom % 4) != 0, ($urandom % 50) == 0);
      if (($urandom % 700) == 0) async_reset_check();
    end
    cyc(); drive(0, 0, 0, 0, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
